// File: rtl/vit_pkg.sv
// Shared definitions for the 802.11a Viterbi decoder frame controller.
// Holds the state encoding, code constants and parameter defaults.
package vit_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DEC_RST = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    DEC_RST = ST_DEC_RST,
    DATA    = ST_DATA,
    DRAIN   = ST_DRAIN,
    DONE    = ST_DONE
  } vitState_e;

  // 802.11a convolutional code: constraint length 7, six zero tail bits.
  localparam int K         = 7;
  localparam int TAIL_BITS = K - 1;

  localparam int LEN_W_DEF     = 12;
  localparam int DRAIN_MAX_DEF = 64;
  localparam int RST_CYC_DEF   = 2;

  // Width of a counter that must reach maxVal inclusive.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/vit_dec_ctrl_if.sv
// Frame-level bus of the Viterbi controller: coded-pair input, decoder
// control/return path, decoded-bit output and frame status.
interface vit_dec_ctrl_if #(
  parameter int LEN_W = 12
);
  logic             iStart;
  logic [LEN_W-1:0] iLen;
  logic [1:0]       iCode;
  logic             iCodeValid;
  logic             oCodeReady;
  logic             oDecRstN;
  logic             oDecEN;
  logic [1:0]       oDecData;
  logic             iDecBit;
  logic             iDecValid;
  logic             oBit;
  logic             oBitValid;
  logic             oBitLast;
  logic             oBusy;
  logic             oDone;
  logic             oErr;

  // Controller side.
  modport master (
    input  iStart, iLen, iCode, iCodeValid, iDecBit, iDecValid,
    output oCodeReady, oDecRstN, oDecEN, oDecData,
           oBit, oBitValid, oBitLast, oBusy, oDone, oErr
  );

  // Surrounding receive chain, decoder and downstream consumer.
  modport slave (
    output iStart, iLen, iCode, iCodeValid, iDecBit, iDecValid,
    input  oCodeReady, oDecRstN, oDecEN, oDecData,
           oBit, oBitValid, oBitLast, oBusy, oDone, oErr
  );
endinterface

// File: rtl/vit_out_fwd.sv
// Decoded-bit forwarder: counts bits against the frame length, registers
// them downstream with valid/last, and drops anything past the frame end.
module vit_out_fwd #(
  parameter int LEN_W = 12
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             clear,
  input  logic             fwdEn,
  input  logic [LEN_W-1:0] lenQ,
  input  logic             decBit,
  input  logic             decValid,
  output logic             bitOut,
  output logic             bitValid,
  output logic             bitLast,
  output logic             frameOut
);

  logic [LEN_W-1:0] outCnt;
  logic [LEN_W-1:0] outCntInc;
  logic             accept;
  logic             lastNow;

  assign accept    = fwdEn & decValid & (outCnt < lenQ);
  assign outCntInc = outCnt + LEN_W'(1);
  assign lastNow   = accept & (outCntInc == lenQ);

  // Frame is complete either already or with the bit accepted this cycle,
  // so a last bit racing the drain limit still counts as success.
  assign frameOut  = (outCnt == lenQ) | lastNow;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      outCnt   <= '0;
      bitOut   <= 1'b0;
      bitValid <= 1'b0;
      bitLast  <= 1'b0;
    end else begin
      bitValid <= accept;
      bitLast  <= lastNow;
      if (accept) begin
        bitOut <= decBit;
      end
      if (clear) begin
        outCnt <= '0;
      end else if (accept) begin
        outCnt <= outCntInc;
      end
    end
  end

endmodule

// File: rtl/vit_dec_ctrl.sv
// Frame sequencer for the hard-decision Viterbi decoder: resets it, feeds
// N coded pairs, flushes traceback with zero pairs, forwards N decoded bits.
module vit_dec_ctrl
  import vit_pkg::*;
#(
  parameter int LEN_W     = LEN_W_DEF,
  parameter int DRAIN_MAX = DRAIN_MAX_DEF,
  parameter int RST_CYC   = RST_CYC_DEF
) (
  input  logic          iClk,
  input  logic          iRst,
  vit_dec_ctrl_if.master bus
);

  localparam int DRN_W = cntWidth(DRAIN_MAX);
  localparam int RST_W = cntWidth(RST_CYC);

  vitState_e        state;
  logic [LEN_W-1:0] lenQ;
  logic [LEN_W-1:0] inCnt;
  logic [DRN_W-1:0] drainCnt;
  logic [DRN_W-1:0] drainNext;
  logic [RST_W-1:0] rstCnt;
  logic             decRstN;
  logic             done;
  logic             err;
  logic             xfer;
  logic             fwdEn;
  logic             frameClr;
  logic             frameOut;

  assign bus.oCodeReady = (state == DATA);
  assign xfer           = bus.oCodeReady & bus.iCodeValid;
  assign bus.oDecEN     = xfer | (state == DRAIN);
  assign bus.oDecData   = (state == DATA) ? bus.iCode : 2'b00;
  assign bus.oBusy      = (state != IDLE);
  assign bus.oDecRstN   = decRstN;
  assign bus.oDone      = done;
  assign bus.oErr       = err;

  assign drainNext = drainCnt + DRN_W'(1);
  assign fwdEn     = (state == DATA) | (state == DRAIN);
  assign frameClr  = (state == IDLE) & bus.iStart;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state    <= IDLE;
      lenQ     <= '0;
      inCnt    <= '0;
      drainCnt <= '0;
      rstCnt   <= '0;
      decRstN  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // Status flags fall back every cycle; only the DONE entry raises them.
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          decRstN <= 1'b1;
          if (bus.iStart) begin
            lenQ     <= bus.iLen;
            inCnt    <= '0;
            drainCnt <= '0;
            rstCnt   <= '0;
            decRstN  <= 1'b0;
            state    <= DEC_RST;
          end
        end
        DEC_RST: begin
          if (rstCnt == RST_W'(RST_CYC - 1)) begin
            decRstN <= 1'b1;
            if (lenQ == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= DATA;
            end
          end else begin
            rstCnt <= rstCnt + RST_W'(1);
          end
        end
        DATA: begin
          if (xfer) begin
            inCnt <= inCnt + LEN_W'(1);
            if (inCnt == lenQ - LEN_W'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          drainCnt <= drainNext;
          if (frameOut) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (drainNext == DRN_W'(DRAIN_MAX)) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  vit_out_fwd #(
    .LEN_W (LEN_W)
  ) u_out_fwd (
    .iClk     (iClk),
    .iRst     (iRst),
    .clear    (frameClr),
    .fwdEn    (fwdEn),
    .lenQ     (lenQ),
    .decBit   (bus.iDecBit),
    .decValid (bus.iDecValid),
    .bitOut   (bus.oBit),
    .bitValid (bus.oBitValid),
    .bitLast  (bus.oBitLast),
    .frameOut (frameOut)
  );

endmodule

// File: doc/vit_dec_ctrl.md
Name: vit_dec_ctrl

Overview:
Frame-level sequencer for the hard-decision Viterbi decoder (vitDecoder) in the 802.11a receive chain. It sits between the deinterleaver/depuncturer output stream and the decoder. Per frame it:
- resets the decoder,
- feeds exactly N coded bit pairs through a valid/ready handshake,
- flushes the traceback with zero pairs,
- forwards exactly N decoded bits downstream, then signals done or timeout.

Parameters:
LEN_W, 12, width of frame length (max 4095 decoded bits per frame)
DRAIN_MAX, 64, max flush cycles after last input pair before timeout
RST_CYC, 2, cycles decoder reset is held low at frame start

Ports:
iClk  in  1  clock (decoder slow clock domain)
iRst  in  1  reset, asynchronous, active-low
iStart  in  1  frame start pulse; sampled only in IDLE
iLen  in  LEN_W  decoded bits in frame (incl. SERVICE/tail/pad); latched on accepted iStart
iCode  in  2  coded pair {A,B} from depuncturer
iCodeValid  in  1  iCode valid
oCodeReady  out  1  controller accepts iCode this cycle
oDecRstN  out  1  registered active-low reset to decoder iRst
oDecEN  out  1  decoder iEN
oDecData  out  2  decoder iData
iDecBit  in  1  decoder oData
iDecValid  in  1  decoder oValid
oBit  out  1  decoded bit downstream
oBitValid  out  1  oBit valid
oBitLast  out  1  marks bit N of frame
oBusy  out  1  high in any state except IDLE
oDone  out  1  one-cycle pulse at frame end
oErr  out  1  one-cycle pulse with oDone on drain timeout

Behaviour:
- Reset values: state=IDLE, oDecRstN=0, oDecEN=0, oDecData=00, oCodeReady=0, oBit/oBitValid/oBitLast=0, oBusy=0, oDone=0, oErr=0, counters=0. After reset release, IDLE drives oDecRstN=1.
- Registered outputs: oDecRstN, oBit, oBitValid, oBitLast, oDone, oErr.
- Combinational outputs:
  - oCodeReady = (state==DATA).
  - oDecEN = (DATA & iCodeValid) | DRAIN.
  - oDecData = iCode in DATA, 00 in DRAIN.
- FSM states: IDLE, DEC_RST, DATA, DRAIN, DONE.
- IDLE -> DEC_RST on iStart. Latch iLen into len_q. Clear in_cnt, out_cnt, drain_cnt.
- DEC_RST:
  - oDecRstN=0 for RST_CYC cycles, then 1.
  - If len_q==0 -> DONE; else -> DATA.
  - Decoder input held idle (EN=0).
- DATA:
  - Handshake transfer when iCodeValid & oCodeReady.
  - Each transfer increments in_cnt.
  - When the transfer with in_cnt==len_q-1 occurs -> DRAIN on the next cycle.
  - Bubbles (iCodeValid=0) stall the decoder via EN=0. No timeout in DATA.
- DRAIN:
  - Feed 00 with EN=1 every cycle; drain_cnt increments.
  - out_cnt==len_q -> DONE.
  - drain_cnt==DRAIN_MAX with out_cnt<len_q -> DONE with error flag set.
- DONE (1 cycle):
  - oDone=1 and oErr=err_flag, asserted on the same registered edge as the DONE entry.
  - -> IDLE.
- Output forwarding:
  - In DATA/DRAIN, each iDecValid with out_cnt<len_q produces oBit=iDecBit, oBitValid=1 next cycle, and increments out_cnt.
  - oBitLast=1 with the bit where out_cnt becomes len_q.
  - iDecValid in IDLE/DEC_RST/DONE, or beyond len_q, is discarded.
- Latency:
  - iStart -> first oCodeReady = RST_CYC+1 cycles.
  - Decoded bit -> oBit: 1 cycle.
- Simultaneous events:
  - Last output bit arriving in the same cycle drain_cnt hits DRAIN_MAX counts as success (oErr=0).
  - iStart while oBusy is ignored.
- Arithmetic: counters are LEN_W bits, except drain_cnt which is clog2(DRAIN_MAX+1) bits. No wrap is reachable because transitions occur at equality.
- Reset mid-frame: everything returns to reset values immediately. The decoder is held in reset via oDecRstN=0 until iRst deasserts. A partial frame produces no oDone.

Decomposition:
- Shared package vit_pkg holds:
  - state encoding localparams (IDLE..DONE);
  - the 802.11a constants K=7 and TAIL_BITS=6;
  - the default DRAIN_MAX.
- One natural sub-module: vit_out_fwd, covering out_cnt, the bit register and last/valid generation. FSM and input counting stay in the top.

Test Plan:
- iLen=24, continuous iCodeValid, decoder model with 20-cycle traceback latency -> oDecRstN low 2 cycles, 24 EN cycles in DATA, then DRAIN until 24 oBitValid; oBitLast on the 24th bit; oDone=1, oErr=0; bits match the encoded reference.
- iLen=24 with iCodeValid toggled 1/0 -> oDecEN high only on transfers; exactly 24 DATA transfers; output identical to the continuous case.
- Decoder model never asserts oValid, iLen=8 -> DRAIN lasts exactly 64 cycles; oDone=1 and oErr=1 together; zero oBitValid.
- Model emits 30 bits for iLen=24 -> only 24 forwarded, oBitLast on the 24th, extras dropped, oErr=0.
- iLen=0 -> DEC_RST then DONE; oDone pulse, no oCodeReady, no oBitValid.
- iRst low mid-DATA (in_cnt=10), second iStart while busy -> immediate IDLE outputs, oDecRstN=0 during reset, no oDone; the iStart pulse is ignored; a fresh frame after release decodes correctly.
